// File: rtl/addsub_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple slice; in subtract mode B is inverted here
// and the caller supplies the +1 through cin on the first slice.
module addsub_digit
    import addsub_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    input  logic             m,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    logic [DIGIT-1:0] b_eff;
    logic [DIGIT:0]   c;

    assign b_eff = (m == MODE_SUB) ? ~b : b;

    // NOTE: every variable gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        s    = '0;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]   = a[i] ^ b_eff[i] ^ c[i];
            c[i+1] = (a[i] & b_eff[i]) | (c[i] & (a[i] ^ b_eff[i]));
        end
    end

    assign cout = c[DIGIT];
    assign cmsb = c[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial two's-complement adder/subtractor, DIGIT bits per cycle.
// Define SERIAL_ADDSUB_SATURATE_EN to clamp the sum on signed overflow.
module serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("serial_addsub: WIDTH must be at least 2");
        end
        if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
            $error("serial_addsub: WIDTH must be an integer multiple of DIGIT");
        end
    endgenerate

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             m_q;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] res;
    logic             cout_q;
    logic             ovf_q;

    logic [DIGIT-1:0] a_sl;
    logic [DIGIT-1:0] b_sl;
    logic [DIGIT-1:0] s_sl;
    logic             c_out;
    logic             c_msb;

    // Slice select by constant part-selects keeps the mux width-exact.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt == CW'(i)) begin
                a_sl = a_q[i*DIGIT +: DIGIT];
                b_sl = b_q[i*DIGIT +: DIGIT];
            end
        end
    end

    addsub_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a    (a_sl),
        .b    (b_sl),
        .cin  (carry),
        .m    (m_q),
        .s    (s_sl),
        .cout (c_out),
        .cmsb (c_msb)
    );

    // NOTE: operand registers carry no reset; they are always loaded on the
    // accept edge before anything reads them, so a reset would only add fan-out.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            a_q <= a;
            b_q <= b;
            m_q <= m;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            cnt       <= '0;
            carry     <= 1'b0;
            res       <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cnt      <= '0;
                        carry    <= (m == MODE_SUB);
                        state    <= RUN;
                        in_ready <= 1'b0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < N; i++) begin
                        if (cnt == CW'(i)) begin
                            res[i*DIGIT +: DIGIT] <= s_sl;
                        end
                    end
                    carry <= c_out;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        cout_q    <= c_out;
                        ovf_q     <= c_out ^ c_msb;
                        state     <= DONE;
                        out_valid <= 1'b1;
`ifdef SERIAL_ADDSUB_SATURATE_EN
                        // Later assignment wins over the slice write above.
                        if (c_out ^ c_msb) begin
                            res <= a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                : {1'b0, {(WIDTH-1){1'b1}}};
                        end
`else
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign sum  = res;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: WIDTH=4/DIGIT=1 and WIDTH=8/DIGIT=4 instances.
module tb_serial_addsub;
    import addsub_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid, in_ready, m, out_valid, out_ready, cout, ovf;
    logic [3:0] a, b, sum;

    logic       w_in_valid, w_in_ready, w_m, w_out_valid, w_out_ready, w_cout, w_ovf;
    logic [7:0] w_a, w_b, w_sum;

    serial_addsub #(.WIDTH(4), .DIGIT(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .m(m), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    serial_addsub #(.WIDTH(8), .DIGIT(4)) dut_w (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .a(w_a), .b(w_b), .m(w_m), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .sum(w_sum), .cout(w_cout), .ovf(w_ovf)
    );

    typedef struct {
        logic [3:0] s;
        logic       c;
        logic       o;
    } res_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       m;
        int         hold;
        logic [3:0] s;
        logic       c;
        logic       o;
    } vec_t;

    res_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] sat4(input logic [3:0] s, input logic o, input logic a_msb);
`ifdef SERIAL_ADDSUB_SATURATE_EN
        if (o) return a_msb ? 4'b1000 : 4'b0111;
`endif
        return s;
    endfunction

    function automatic logic [7:0] sat8(input logic [7:0] s, input logic o, input logic a_msb);
`ifdef SERIAL_ADDSUB_SATURATE_EN
        if (o) return a_msb ? 8'h80 : 8'h7F;
`endif
        return s;
    endfunction

    // Reference: unsigned add for sum/carry, sign rules for overflow.
    function automatic res_t model4(input logic [3:0] ai, input logic [3:0] bi, input logic mi);
        res_t       r;
        logic [4:0] t;
        t   = {1'b0, ai} + {1'b0, (mi == MODE_SUB) ? ~bi : bi} + {4'b0, mi};
        r.s = t[3:0];
        r.c = t[4];
        if (mi == MODE_SUB) r.o = (ai[3] != bi[3]) && (r.s[3] != ai[3]);
        else                r.o = (ai[3] == bi[3]) && (r.s[3] != ai[3]);
        r.s = sat4(r.s, r.o, ai[3]);
        return r;
    endfunction

    task automatic run_op(input logic [3:0] ai, input logic [3:0] bi, input logic mi,
                          input int hold, input res_t exp_r);
        int   lat;
        res_t got;
        lat = 0;
        while (!in_ready && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check("in_ready_idle", in_ready, 1);
        a = ai; b = bi; m = mi; in_valid = 1'b1;
        @(posedge clk); #1;
        sb.push_back(exp_r);
        in_valid = 1'b0;
        a = 4'($urandom); b = 4'($urandom); m = ~mi;
        check("in_ready_busy", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
            a = 4'($urandom); b = 4'($urandom);
        end
        check("latency", lat, 4);
        got = sb.pop_front();
        check("sum", sum, got.s);
        check("cout", cout, got.c);
        check("ovf", ovf, got.o);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_result", {sum, cout, ovf}, {got.s, got.c, got.o});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
    endtask

    task automatic run_op8(input logic [7:0] ai, input logic [7:0] bi, input logic mi,
                           input logic [7:0] es, input logic ec, input logic eo);
        int lat;
        w_a = ai; w_b = bi; w_m = mi; w_in_valid = 1'b1;
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        w_a = 8'($urandom); w_b = 8'($urandom);
        lat = 0;
        while (!w_out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check("w_latency", lat, 2);
        check("w_sum", w_sum, sat8(es, eo, ai[7]));
        check("w_cout", w_cout, ec);
        check("w_ovf", w_ovf, eo);
        w_out_ready = 1'b1;
        @(posedge clk); #1;
        w_out_ready = 1'b0;
        check("w_release", w_in_ready, 1);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{4'b1010, 4'b1100, MODE_ADD, 0, 4'b0110, 1'b1, 1'b1};
        vecs[1] = '{4'b1111, 4'b1010, MODE_SUB, 0, 4'b0101, 1'b1, 1'b0};
        vecs[2] = '{4'b1010, 4'b0110, MODE_SUB, 1, 4'b0100, 1'b1, 1'b1};
        vecs[3] = '{4'b1001, 4'b0100, MODE_SUB, 5, 4'b0101, 1'b1, 1'b1};
        vecs[4] = '{4'b1000, 4'b1000, MODE_SUB, 2, 4'b0000, 1'b1, 1'b0};
        vecs[5] = '{4'b1000, 4'b0001, MODE_SUB, 0, 4'b0111, 1'b1, 1'b1};
        vecs[6] = '{4'b0111, 4'b0001, MODE_ADD, 0, 4'b1000, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; m = 1'b0;
        w_in_valid = 1'b0; w_out_ready = 1'b0; w_a = '0; w_b = '0; w_m = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", {sum, cout, ovf}, 6'b0);

        foreach (vecs[i]) begin
            res_t e;
            e.s = sat4(vecs[i].s, vecs[i].o, vecs[i].a[3]);
            e.c = vecs[i].c;
            e.o = vecs[i].o;
            run_op(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].hold, e);
        end

        // Reset during the second RUN cycle discards the operation.
        a = 4'b1010; b = 4'b0011; m = MODE_ADD; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrun_in_ready", in_ready, 1);
        check("midrun_out_valid", out_valid, 0);
        check("midrun_sum", sum, 0);
        begin
            logic seen;
            seen = 1'b0;
            repeat (6) begin
                @(posedge clk); #1;
                seen = seen | out_valid;
            end
            check("midrun_no_result", seen, 0);
        end
        run_op(4'b0011, 4'b0001, MODE_ADD, 0, model4(4'b0011, 4'b0001, MODE_ADD));

        for (int i = 0; i < 16; i++) begin
            logic [3:0] ra, rb;
            logic       rm;
            ra = 4'($urandom); rb = 4'($urandom); rm = 1'($urandom);
            run_op(ra, rb, rm, $urandom_range(0, 2), model4(ra, rb, rm));
        end

        run_op8(8'h7F, 8'h01, MODE_ADD, 8'h80, 1'b0, 1'b1);
        run_op8(8'h80, 8'h80, MODE_SUB, 8'h00, 1'b1, 1'b0);
        run_op8(8'h35, 8'h4C, MODE_SUB, 8'hE9, 1'b0, 1'b0);

        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; SHALL be at least 2.
REQ-002 Parameter DIGIT, default 1: bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT (elaboration error otherwise).
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  operands a, b and m are valid.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 a  input  WIDTH  operand A, two's complement.
REQ-008 b  input  WIDTH  operand B, two's complement.
REQ-009 m  input  1  mode: 0 = A+B, 1 = A-B.
REQ-010 out_valid  output  1  sum, cout and ovf are valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 sum  output  WIDTH  result, wrapped or saturated per REQ-026.
REQ-013 cout  output  1  carry out of the MSB; in subtract mode, 1 = no unsigned borrow.
REQ-014 ovf  output  1  signed overflow: carry into the MSB XOR carry out of the MSB.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
- IDLE: in_ready=1, out_valid=0.
- RUN: in_ready=0, out_valid=0.
- DONE: in_ready=0, out_valid=1.
REQ-016 Accept: in IDLE with in_valid=1 on an edge, the block SHALL latch a, b and m, clear the digit counter, preset the internal carry to m, and enter RUN.
REQ-017 In RUN, each edge SHALL process one DIGIT-bit slice, LSB slice first: A slice + (B slice XOR {DIGIT{m}}) + carry.
- The sum slice SHALL be stored in its position in the result register.
- The slice carry-out SHALL become the next slice's carry-in.
REQ-018 After N = WIDTH/DIGIT RUN edges, the block SHALL enter DONE; out_valid is high exactly N cycles after the accept edge.
REQ-019 cout and ovf SHALL be captured on the final RUN edge and held stable with sum for the whole of DONE.
REQ-020 In DONE, sum, cout and ovf SHALL stay constant while out_ready=0 (unbounded backpressure).
REQ-021 In DONE with out_ready=1 on an edge, the block SHALL return to IDLE; the next accept is possible no earlier than the following edge.
REQ-022 Operand inputs SHALL be ignored outside the accept edge; changes to them during RUN or DONE SHALL NOT affect the result.
REQ-023 Boundary cases:
- DIGIT=WIDTH SHALL give N=1.
- a=b=most negative value with m=1 SHALL give sum=0, cout=1, ovf=0.
- Most negative minus 1 SHALL set ovf=1.
REQ-024 The result SHALL equal (a + (m ? ~b+1 : b)) mod 2^WIDTH for every input.

Reset
REQ-025 rst=1 on an edge SHALL force IDLE and clear the counter, carry, sum, cout, ovf and out_valid, including when it occurs mid-RUN or in DONE; the in-flight operation is discarded and no result is produced.

Configuration
REQ-026 Macro SERIAL_ADDSUB_SATURATE_EN:
- Defined: when ovf=1, sum SHALL be clamped to 0111..1 if the latched a is non-negative, else to 1000..0; ovf and cout are still reported unchanged.
- Undefined: sum SHALL always be the wrapped result and no clamp logic exists.

Structure
REQ-027 Package addsub_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the mode constants MODE_ADD=0 and MODE_SUB=1.
REQ-028 Sub-module addsub_digit SHALL be a combinational, DIGIT-parameterised ripple slice with inputs a, b, cin, m and outputs s, cout, cmsb (carry into the slice's top bit, for ovf); serial_addsub SHALL instantiate it once.

Verification (WIDTH=4, DIGIT=1 unless stated)
REQ-029 The bench SHALL cover these directed scenarios:
- a=1010, b=1100, m=0 -> out_valid 4 cycles after accept; sum=0110, cout=1, ovf=1 (saturated build: sum=1000).
- a=1111, b=1010, m=1 -> sum=0101, cout=1, ovf=0.
- a=1010, b=0110, m=1 -> sum=0100, cout=1, ovf=1 (saturated build: sum=1000).
- a=1001, b=0100, m=1, out_ready held 0 for 5 cycles -> sum=0101, cout=1, ovf=1 stable throughout; in_ready=0 until one edge after out_ready=1.
- rst pulsed on the 2nd RUN cycle -> next cycle in IDLE, out_valid=0, sum=0000; a new operation a=0011, b=0001, m=0 -> sum=0100.
- WIDTH=8, DIGIT=4: a=0x7F, b=0x01, m=0 -> out_valid 2 cycles after accept; sum=0x80, ovf=1, cout=0.
